// File: rtl/rd_track_if.sv
// rd_track_if: decode-side bundle between the decode stage and the destination
// register tracker.
//   master : decode / forwarding side (drives id_*, flush; reads tracker outputs)
//   slave  : rd_track (reads id_*, flush; drives rdi_buf_*, legal_*, stall,
//            id_accept, mul_busy)
interface rd_track_if #(
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rd;
  logic             id_wen;
  logic             id_is_load;
  logic             id_is_mul;
  logic [REG_W-1:0] id_rsa;
  logic [REG_W-1:0] id_rsb;
  logic             id_rsa_used;
  logic             id_rsb_used;
  logic             flush;

  logic [REG_W-1:0] rdi_buf_1;
  logic             legal_1;
  logic [REG_W-1:0] rdi_buf_2;
  logic             legal_2;
  logic             stall;
  logic             id_accept;
  logic             mul_busy;

  modport master (
    output id_valid, id_rd, id_wen, id_is_load, id_is_mul,
           id_rsa, id_rsb, id_rsa_used, id_rsb_used, flush,
    input  rdi_buf_1, legal_1, rdi_buf_2, legal_2, stall, id_accept, mul_busy
  );

  modport slave (
    input  id_valid, id_rd, id_wen, id_is_load, id_is_mul,
           id_rsa, id_rsb, id_rsa_used, id_rsb_used, flush,
    output rdi_buf_1, legal_1, rdi_buf_2, legal_2, stall, id_accept, mul_busy
  );
endinterface

// File: rtl/rd_track.sv
// rd_track: destination-register tracker for EX (stage 1) and MEM (stage 2).
// Records the destination of each in-flight instruction, reports which stage
// results are forwardable, and stalls decode on load-use hazards and while a
// multiply occupies stage 1.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rd_track_if.slave (decode fields in, tracker status out)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | stage 1 advances every cycle
// MUL_WAIT | multiply held in stage 1; r_cnt counts remaining held cycles
module rd_track #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 3
) (
  input logic      clk,
  input logic      rst,
  rd_track_if.slave bus
);

  localparam int CNT_W = $clog2(MUL_LAT) + 1;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             load;
    logic             mul;
  } stage_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  stage_t           r_s1;
  stage_t           r_s2;
  stage_t           w_dec;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hold1;
  logic             w_luse;
  logic             w_stall;
  logic             w_accept;
  logic             w_unused_fields;

  // Fields kept for visibility of the in-flight instruction but not consumed.
  assign w_unused_fields = ^{r_s1.mul, r_s2.load, r_s2.mul, r_s2.v & r_s2.wen};

  // A non-writing instruction carries rd=0 so it can never look forwardable.
  assign w_dec = '{v:    1'b1,
                   rd:   bus.id_wen ? bus.id_rd : '0,
                   wen:  bus.id_wen,
                   load: bus.id_is_load,
                   mul:  bus.id_is_mul};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (w_accept && bus.id_is_mul && (MUL_LAT > 1)) w_state_nxt = MUL_WAIT;
      MUL_WAIT: if (r_cnt == CNT_W'(1)) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_hold1 = (r_state == MUL_WAIT);
    w_luse  = bus.id_valid & r_s1.v & r_s1.load & r_s1.wen & (r_s1.rd != '0) &
              ((bus.id_rsa_used & (bus.id_rsa == r_s1.rd)) |
               (bus.id_rsb_used & (bus.id_rsb == r_s1.rd)));
    w_stall = w_hold1 | w_luse;
    // Gated by rst so every output reads 0 while reset is held, even with
    // decode presenting a valid instruction.
    w_accept = bus.id_valid & ~w_stall & ~bus.flush & ~rst;

    bus.stall     = w_stall;
    bus.id_accept = w_accept;
    bus.mul_busy  = w_hold1;
    bus.rdi_buf_1 = r_s1.rd;
    bus.rdi_buf_2 = r_s2.rd;
    // A load in stage 1 has no data yet; a multiply only on its last cycle.
    bus.legal_1   = r_s1.v & r_s1.wen & (r_s1.rd != '0) & ~r_s1.load & ~w_hold1;
    bus.legal_2   = r_s2.v & r_s2.wen & (r_s2.rd != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_cnt <= '0;
    end else if (w_hold1) begin
      r_s2  <= '0;
      r_cnt <= r_cnt - 1'b1;
    end else if (w_accept) begin
      r_s2 <= r_s1;
      r_s1 <= w_dec;
      if (bus.id_is_mul && (MUL_LAT > 1)) r_cnt <= CNT_W'(MUL_LAT - 1);
    end else begin
      r_s2 <= r_s1;
      r_s1 <= '0;
    end
  end

endmodule

// File: tb/tb_rd_track.sv
module tb_rd_track;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [14:0] e;
  logic [4:0]  q_rd2[$];

  always #5 clk = ~clk;

  rd_track_if #(.REG_W(5)) bus ();

  rd_track #(.REG_W(5), .MUL_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // {rdi_buf_1, legal_1, rdi_buf_2, legal_2, stall, id_accept, mul_busy}
  function automatic logic [14:0] obs();
    return {bus.rdi_buf_1, bus.legal_1, bus.rdi_buf_2, bus.legal_2,
            bus.stall, bus.id_accept, bus.mul_busy};
  endfunction

  function automatic logic [14:0] ev(input logic [4:0] rd1, input logic l1,
                                     input logic [4:0] rd2, input logic l2,
                                     input logic st, input logic acc, input logic busy);
    return {rd1, l1, rd2, l2, st, acc, busy};
  endfunction

  task automatic drv(input logic v, input logic [4:0] rd, input logic wen,
                     input logic ld, input logic mul,
                     input logic [4:0] rsa, input logic rsa_u,
                     input logic [4:0] rsb, input logic rsb_u, input logic fl);
    bus.id_valid    = v;
    bus.id_rd       = rd;
    bus.id_wen      = wen;
    bus.id_is_load  = ld;
    bus.id_is_mul   = mul;
    bus.id_rsa      = rsa;
    bus.id_rsa_used = rsa_u;
    bus.id_rsb      = rsb;
    bus.id_rsb_used = rsb_u;
    bus.flush       = fl;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    idle();
    #12 rst = 1'b0;
    cyc();
    drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    e = ev(6, 1, 4, 1, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL pre_reset got=%h want=%h", obs(), e); end
    #2 rst = 1'b1;
    #1;
    e = '0;
    total++; if (obs() !== e) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs(), e); end
    rst = 1'b0;
    #1;
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    e = ev(0, 0, 0, 0, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL post_reset_accept got=%h want=%h", obs(), e); end
    q_rd2.push_back(5);
    cyc();
    idle();
    e = ev(5, 1, 0, 0, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL alu_stage1 got=%h want=%h", obs(), e); end
    cyc();
    e = ev(0, 0, q_rd2.pop_front(), 1, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL alu_stage2 got=%h want=%h", obs(), e); end
  endtask

  task automatic test_load_use();
    drain();
    drv(1, 7, 1, 1, 0, 0, 0, 0, 0, 0);
    e = ev(0, 0, 0, 0, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL lu_load_accept got=%h want=%h", obs(), e); end
    q_rd2.push_back(7);
    cyc();
    drv(1, 8, 1, 0, 0, 7, 1, 0, 0, 0);
    e = ev(7, 0, 0, 0, 1, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL lu_stall got=%h want=%h", obs(), e); end
    cyc();
    e = ev(0, 0, q_rd2.pop_front(), 1, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL lu_release got=%h want=%h", obs(), e); end
    q_rd2.push_back(8);
    cyc();
    idle();
    e = ev(8, 1, 0, 0, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL lu_consumer_s1 got=%h want=%h", obs(), e); end
    cyc();
    e = ev(0, 0, q_rd2.pop_front(), 1, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL lu_consumer_s2 got=%h want=%h", obs(), e); end
  endtask

  task automatic test_mul();
    drain();
    drv(1, 9, 1, 0, 1, 0, 0, 0, 0, 0);
    e = ev(0, 0, 0, 0, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL mul_accept got=%h want=%h", obs(), e); end
    q_rd2.push_back(9);
    cyc();
    drv(1, 10, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      e = ev(9, 0, 0, 0, 1, 0, 1);
      total++; if (obs() !== e) begin bad++; $display("FAIL mul_hold%0d got=%h want=%h", i, obs(), e); end
      cyc();
    end
    e = ev(9, 1, 0, 0, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL mul_final got=%h want=%h", obs(), e); end
    q_rd2.push_back(10);
    cyc();
    idle();
    e = ev(10, 1, q_rd2.pop_front(), 1, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL mul_stage2 got=%h want=%h", obs(), e); end
    cyc();
    e = ev(0, 0, q_rd2.pop_front(), 1, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL mul_next_s2 got=%h want=%h", obs(), e); end
  endtask

  task automatic test_hold_drain();
    drain();
    drv(1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
    q_rd2.push_back(11);
    cyc();
    drv(1, 12, 1, 0, 1, 0, 0, 0, 0, 0);
    e = ev(11, 1, 0, 0, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL hd_mul_accept got=%h want=%h", obs(), e); end
    q_rd2.push_back(12);
    cyc();
    idle();
    e = ev(12, 0, q_rd2.pop_front(), 1, 1, 0, 1);
    total++; if (obs() !== e) begin bad++; $display("FAIL hd_first_hold got=%h want=%h", obs(), e); end
    cyc();
    e = ev(12, 0, 0, 0, 1, 0, 1);
    total++; if (obs() !== e) begin bad++; $display("FAIL hd_drained got=%h want=%h", obs(), e); end
    cyc();
    e = ev(12, 1, 0, 0, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL hd_final got=%h want=%h", obs(), e); end
    cyc();
    e = ev(0, 0, q_rd2.pop_front(), 1, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL hd_stage2 got=%h want=%h", obs(), e); end
  endtask

  task automatic test_reg_zero();
    drain();
    drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    drv(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    e = ev(0, 0, 0, 0, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL rz_alu_s1 got=%h want=%h", obs(), e); end
    cyc();
    drv(1, 13, 0, 0, 0, 0, 1, 0, 1, 0);
    e = ev(0, 0, 0, 0, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL rz_no_stall got=%h want=%h", obs(), e); end
    cyc();
    idle();
    e = ev(0, 0, 0, 0, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL rz_nowen_rd got=%h want=%h", obs(), e); end
  endtask

  task automatic test_flush();
    drain();
    drv(1, 14, 1, 0, 0, 0, 0, 0, 0, 0);
    q_rd2.push_back(14);
    cyc();
    drv(1, 15, 1, 0, 0, 0, 0, 0, 0, 1);
    e = ev(14, 1, 0, 0, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL fl_no_accept got=%h want=%h", obs(), e); end
    cyc();
    drv(1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    e = ev(0, 0, q_rd2.pop_front(), 1, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL fl_bubble got=%h want=%h", obs(), e); end
    cyc();
    drv(1, 20, 1, 0, 0, 0, 0, 2, 1, 1);
    e = ev(2, 0, 0, 0, 1, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL fl_with_stall got=%h want=%h", obs(), e); end
    cyc();
    idle();
    e = ev(0, 0, 2, 1, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL fl_after_stall got=%h want=%h", obs(), e); end
  endtask

  task automatic test_overlap();
    drain();
    drv(1, 3, 1, 1, 0, 0, 0, 0, 0, 0);
    q_rd2.push_back(3);
    cyc();
    drv(1, 16, 1, 0, 1, 3, 1, 0, 0, 0);
    e = ev(3, 0, 0, 0, 1, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL ov_stall got=%h want=%h", obs(), e); end
    cyc();
    e = ev(0, 0, q_rd2.pop_front(), 1, 0, 1, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL ov_accept got=%h want=%h", obs(), e); end
    q_rd2.push_back(16);
    cyc();
    idle();
    for (int i = 0; i < 2; i++) begin
      e = ev(16, 0, 0, 0, 1, 0, 1);
      total++; if (obs() !== e) begin bad++; $display("FAIL ov_busy%0d got=%h want=%h", i, obs(), e); end
      cyc();
    end
    e = ev(16, 1, 0, 0, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL ov_final got=%h want=%h", obs(), e); end
    cyc();
    e = ev(0, 0, q_rd2.pop_front(), 1, 0, 0, 0);
    total++; if (obs() !== e) begin bad++; $display("FAIL ov_stage2 got=%h want=%h", obs(), e); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mul();
    test_hold_drain();
    test_reg_zero();
    test_flush();
    test_overlap();
    total++;
    if (q_rd2.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", q_rd2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
